// File: rtl/light_sep_apb_sequencer_if.sv
// light_sep_apb_sequencer_if: host command/response and APB signals of the LightSeparator sequencer.
//  cmd_valid/cmd_ready/cmd_op/cmd_addr/cmd_wdata/cmd_mask : host command push
//  rsp_valid/rsp_rdata/rsp_err                            : one response per command
//  busy                                                   : work queued or in flight
//  PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA                : APB towards LightSeparator
//  master modport = sequencer, slave modport = host plus APB slave side
interface light_sep_apb_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_mask;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, PRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, PRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy,
               PADDR, PSEL, PENABLE, PWRITE, PWDATA
    );
endinterface

// File: rtl/light_sep_apb_sequencer.sv
// light_sep_apb_sequencer: APB master running queued write/read/poll commands into the LightSeparator slave.
//  clk : rising-edge clock
//  rst : asynchronous active-high reset
//  bus : light_sep_apb_sequencer_if.master (command FIFO push, response pulse, busy, APB master side)
//  Command ops: 00 write, 01 read, 10 poll (masked compare, retried with an idle gap), 11 illegal.
module light_sep_apb_sequencer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int POLL_MAX   = 255,
    parameter int POLL_GAP   = 4
) (
    input logic                       clk,
    input logic                       rst,
    light_sep_apb_sequencer_if.master bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(POLL_MAX + 1);
    localparam int GW = $clog2(POLL_GAP + 1);
    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_POLL = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_t;

    state_t            state, state_d;
    logic [1:0]        f_op    [FIFO_DEPTH];
    logic [ADDR_W-1:0] f_addr  [FIFO_DEPTH];
    logic [DATA_W-1:0] f_wdata [FIFO_DEPTH];
    logic [DATA_W-1:0] f_mask  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              full, empty, push, pop, load, illegal, done, match, last_try, gap_done;
    logic [1:0]        head_op, cur_op;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_wdata, head_mask, cur_wdata, cur_mask;
    logic [AW-1:0]     attempts;
    logic [GW-1:0]     gap_cnt;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rsp_rdata_q, rsp_rdata_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;

    assign full       = count == CW'(FIFO_DEPTH);
    assign empty      = count == '0;
    assign push       = bus.cmd_valid && !full;
    // The head is consumed whenever the FSM is ready for a new command, including straight out of RESP.
    assign pop        = (state == IDLE || state == RESP) && !empty;
    assign head_op    = f_op[rd_ptr];
    assign head_addr  = f_addr[rd_ptr];
    assign head_wdata = f_wdata[rd_ptr];
    assign head_mask  = f_mask[rd_ptr];
    assign load       = pop && head_op != OP_ILL;
    assign illegal    = pop && head_op == OP_ILL;
    assign done       = state == ACCESS && state_d == RESP;
    assign match      = ((bus.PRDATA ^ cur_wdata) & cur_mask) == '0;
    // attempts counts completed ACCESS cycles, so the current one is the last when it equals POLL_MAX-1.
    assign last_try   = attempts == AW'(POLL_MAX - 1);
    assign gap_done   = gap_cnt == GW'(POLL_GAP - 1);

    always_ff @(posedge clk) begin
        if (push) begin
            f_op[wr_ptr]    <= bus.cmd_op;
            f_addr[wr_ptr]  <= bus.cmd_addr;
            f_wdata[wr_ptr] <= bus.cmd_wdata;
            f_mask[wr_ptr]  <= bus.cmd_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, RESP: state_d = empty ? IDLE : head_op == OP_ILL ? RESP : SETUP;
            SETUP:      state_d = ACCESS;
            ACCESS:     state_d = (cur_op != OP_POLL || match || last_try) ? RESP : GAP;
            GAP:        state_d = gap_done ? SETUP : GAP;
            default:    state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the upcoming state.
    always_comb begin
        psel_d      = state_d == SETUP || state_d == ACCESS;
        penable_d   = state_d == ACCESS;
        rsp_valid_d = state_d == RESP;
        paddr_d     = load ? head_addr : paddr_q;
        pwrite_d    = load ? head_op == OP_WR : pwrite_q;
        pwdata_d    = load ? (head_op == OP_WR ? head_wdata : '0) : pwdata_q;
        rsp_rdata_d = done ? (cur_op == OP_WR ? '0 : bus.PRDATA) : illegal ? '0 : rsp_rdata_q;
        rsp_err_d   = done ? cur_op == OP_POLL && !match : illegal ? 1'b1 : rsp_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cur_op      <= '0;
            cur_wdata   <= '0;
            cur_mask    <= '0;
            attempts    <= '0;
            gap_cnt     <= '0;
        end else begin
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (load) begin
                cur_op    <= head_op;
                cur_wdata <= head_wdata;
                cur_mask  <= head_mask;
            end
            attempts <= load ? '0 : state == ACCESS ? attempts + 1'b1 : attempts;
            gap_cnt  <= state == GAP ? gap_cnt + 1'b1 : '0;
        end
    end

    assign bus.cmd_ready = !full;
    assign bus.busy      = !empty || state != IDLE;
    assign bus.PADDR     = paddr_q;
    assign bus.PSEL      = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PWRITE    = pwrite_q;
    assign bus.PWDATA    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_light_sep_apb_sequencer.sv
// tb_light_sep_apb_sequencer: directed checks of the LightSeparator APB sequencer.
module tb_light_sep_apb_sequencer;
    localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_POLL = 2'd2, OP_ILL = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    light_sep_apb_sequencer_if #(.ADDR_W(16), .DATA_W(32)) a_if ();
    light_sep_apb_sequencer_if #(.ADDR_W(16), .DATA_W(32)) b_if ();

    light_sep_apb_sequencer #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .POLL_MAX(255), .POLL_GAP(4))
        dut (.clk(clk), .rst(rst), .bus(a_if.master));
    light_sep_apb_sequencer #(.ADDR_W(16), .DATA_W(32), .FIFO_DEPTH(4), .POLL_MAX(3), .POLL_GAP(4))
        dut_b (.clk(clk), .rst(rst), .bus(b_if.master));

    int n_assert = 0, n_fail = 0;
    int cyc = 0, acc_cnt = 0, poll_base = 0, viol = 0, b_acc = 0;
    int na, nr, np;
    logic mode = 1'b0;
    logic [31:0] mem [256];
    logic prev_setup = 1'b0;
    logic [48:0] prev_cmd = '0;
    logic [48:0] acc_q[$];
    logic [32:0] rsp_q[$], b_rsp_q[$];
    int acc_cyc_q[$], push_cyc_q[$], rsp_cyc_q[$];

    // Slave model: echo memory in mode 0; in mode 1 returns 0 for three accesses, then 1.
    assign a_if.PRDATA = mode ? ((acc_cnt - poll_base >= 3) ? 32'd1 : 32'd0) : mem[a_if.PADDR[7:0]];
    assign b_if.PRDATA = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_if.PENABLE && !a_if.PSEL) viol <= viol + 1;
        if (a_if.PSEL && a_if.PENABLE) begin
            if (!prev_setup || prev_cmd !== {a_if.PWRITE, a_if.PADDR, a_if.PWDATA}) viol <= viol + 1;
            acc_q.push_back({a_if.PWRITE, a_if.PADDR, a_if.PWDATA});
            acc_cyc_q.push_back(cyc);
            acc_cnt <= acc_cnt + 1;
            if (a_if.PWRITE) mem[a_if.PADDR[7:0]] <= a_if.PWDATA;
        end
        prev_setup <= a_if.PSEL && !a_if.PENABLE;
        prev_cmd   <= {a_if.PWRITE, a_if.PADDR, a_if.PWDATA};
        if (a_if.cmd_valid && a_if.cmd_ready) push_cyc_q.push_back(cyc);
        if (a_if.rsp_valid) begin
            rsp_q.push_back({a_if.rsp_err, a_if.rsp_rdata});
            rsp_cyc_q.push_back(cyc);
        end
        if (b_if.PSEL && b_if.PENABLE) b_acc <= b_acc + 1;
        if (b_if.rsp_valid) b_rsp_q.push_back({b_if.rsp_err, b_if.rsp_rdata});
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wd, input logic [31:0] mk);
        logic ok;
        ok = 1'b0;
        a_if.cmd_valid = 1'b1;
        a_if.cmd_op    = op;
        a_if.cmd_addr  = addr;
        a_if.cmd_wdata = wd;
        a_if.cmd_mask  = mk;
        for (int i = 0; i < 500 && !ok; i++) begin
            ok = a_if.cmd_ready;
            tick(1);
        end
        a_if.cmd_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 3000 && rsp_q.size() < n; i++) tick(1);
        chk("rsp_count", rsp_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a_if.cmd_valid = 0; a_if.cmd_op = 0; a_if.cmd_addr = 0; a_if.cmd_wdata = 0; a_if.cmd_mask = 0;
        b_if.cmd_valid = 0; b_if.cmd_op = 0; b_if.cmd_addr = 0; b_if.cmd_wdata = 0; b_if.cmd_mask = 0;
        tick(2);
        chk("rst_cmd_ready", a_if.cmd_ready, 1);
        chk("rst_psel", a_if.PSEL, 0);
        chk("rst_penable", a_if.PENABLE, 0);
        chk("rst_rsp_valid", a_if.rsp_valid, 0);
        chk("rst_busy", a_if.busy, 0);
        chk("rst_paddr", a_if.PADDR, 0);
        rst = 1'b0;
        tick(2);

        // reset asserted while a write is in its ACCESS phase
        nr = rsp_q.size();
        push(OP_WR, 16'h0070, 32'h1234_5678, 32'h0);
        for (int i = 0; i < 20 && !(a_if.PSEL && a_if.PENABLE); i++) tick(1);
        chk("t1_in_access", a_if.PSEL && a_if.PENABLE, 1);
        rst = 1'b1;
        #1;
        chk("t1_psel", a_if.PSEL, 0);
        chk("t1_penable", a_if.PENABLE, 0);
        chk("t1_cmd_ready", a_if.cmd_ready, 1);
        chk("t1_busy", a_if.busy, 0);
        chk("t1_rsp_valid", a_if.rsp_valid, 0);
        tick(1);
        rst = 1'b0;
        tick(6);
        chk("t1_no_rsp", rsp_q.size(), nr);

        // write then read back through the echo slave
        na = acc_q.size(); nr = rsp_q.size(); np = push_cyc_q.size();
        push(OP_WR, 16'h0010, 32'hA5A5_0001, 32'h0);
        push(OP_RD, 16'h0010, 32'h0, 32'h0);
        wait_rsp(nr + 2);
        chk("t2_acc_wr", acc_q[na], {1'b1, 16'h0010, 32'hA5A5_0001});
        chk("t2_acc_rd", acc_q[na+1], {1'b0, 16'h0010, 32'h0});
        chk("t2_rsp_wr", rsp_q[nr], 33'h0);
        chk("t2_rsp_rd", rsp_q[nr+1], {1'b0, 32'hA5A5_0001});
        chk("t2_lat_access", acc_cyc_q[na] - push_cyc_q[np], 3);
        chk("t2_lat_rsp", rsp_cyc_q[nr] - push_cyc_q[np], 4);
        chk("t2_back_to_back", rsp_cyc_q[nr+1] - rsp_cyc_q[nr], 3);
        tick(2);
        chk("t2_idle_busy", a_if.busy, 0);

        // long poll keeps the FSM busy while four writes fill the FIFO, fifth waits for a pop
        mode = 1'b1;
        poll_base = acc_cnt;
        na = acc_q.size(); nr = rsp_q.size();
        push(OP_POLL, 16'h0020, 32'h1, 32'h1);
        for (int i = 0; i < 4; i++) push(OP_WR, 16'(16'h0030 + i), 32'(32'h100 + i), 32'h0);
        chk("t3_full", a_if.cmd_ready, 0);
        chk("t3_busy", a_if.busy, 1);
        push(OP_WR, 16'h0034, 32'h104, 32'h0);
        chk("t3_w5_after_pop", rsp_q.size(), nr + 1);
        wait_rsp(nr + 6);
        for (int i = 0; i < 4; i++) chk("t4_poll_acc", acc_q[na+i], {1'b0, 16'h0020, 32'h0});
        for (int i = 0; i < 3; i++) chk("t4_gap", acc_cyc_q[na+i+1] - acc_cyc_q[na+i], 6);
        chk("t4_poll_rsp", rsp_q[nr], {1'b0, 32'h1});
        for (int i = 0; i < 5; i++) chk("t3_order", acc_q[na+4+i], {1'b1, 16'(16'h0030 + i), 32'(32'h100 + i)});
        for (int i = 1; i < 6; i++) chk("t3_rsp", rsp_q[nr+i], 33'h0);
        chk("t3_acc_total", acc_q.size(), na + 9);

        // poll timeout on the POLL_MAX=3 instance, slave always returns 0
        b_if.cmd_valid = 1'b1; b_if.cmd_op = OP_POLL; b_if.cmd_addr = 16'h0040;
        b_if.cmd_wdata = 32'h1; b_if.cmd_mask = 32'h1;
        chk("t5_ready", b_if.cmd_ready, 1);
        tick(1);
        b_if.cmd_valid = 1'b0;
        for (int i = 0; i < 200 && b_rsp_q.size() == 0; i++) tick(1);
        chk("t5_rsp_count", b_rsp_q.size(), 1);
        chk("t5_accesses", b_acc, 3);
        chk("t5_rsp", b_rsp_q[0], {1'b1, 32'h0});

        // illegal op between two writes
        mode = 1'b0;
        na = acc_q.size(); nr = rsp_q.size();
        push(OP_WR, 16'h0050, 32'h1111_1111, 32'h0);
        push(OP_ILL, 16'h0060, 32'h2222_2222, 32'h0);
        push(OP_WR, 16'h0054, 32'h3333_3333, 32'h0);
        wait_rsp(nr + 3);
        chk("t6_acc_count", acc_q.size(), na + 2);
        chk("t6_acc0", acc_q[na], {1'b1, 16'h0050, 32'h1111_1111});
        chk("t6_acc1", acc_q[na+1], {1'b1, 16'h0054, 32'h3333_3333});
        chk("t6_rsp0", rsp_q[nr], 33'h0);
        chk("t6_rsp_ill", rsp_q[nr+1], {1'b1, 32'h0});
        chk("t6_rsp2", rsp_q[nr+2], 33'h0);

        tick(2);
        chk("apb_protocol", viol, 0);
        chk("final_busy", a_if.busy, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
